// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron accumulate stage.
package neuron_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_e;

  // Accumulator width: product width, plus headroom for NUM_IN terms,
  // plus one bit for the bias term.
  function automatic int acc_width(input int n, input int num_in);
    return n + $clog2(num_in + 1) + 1;
  endfunction

  // Fixed-point 1.0 in Q(N-P).P, for stimulus construction.
  function automatic longint Q_ONE(input int p);
    return longint'(1) << p;
  endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Product-in / activation-out handshake bundle for neuron_accumulator.
interface neuron_accumulator_if #(
  parameter int N      = 24,
  parameter int NUM_IN = 16
);
  localparam int CNT_W = $clog2(NUM_IN + 1);

  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic signed [N-1:0] bias;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_data;
  logic [CNT_W-1:0]    beat_cnt;

  modport master (
    output in_valid, in_data, bias, out_ready,
    input  in_ready, out_valid, out_data, beat_cnt
  );

  modport slave (
    input  in_valid, in_data, bias, out_ready,
    output in_ready, out_valid, out_data, beat_cnt
  );
endinterface

// File: rtl/neuron_narrow_relu.sv
// Narrow a widened accumulator sum back to N bits and apply ReLU.
// Narrowing mode: define NEURON_ACC_SAT_EN for saturation, otherwise the
// low N bits are kept (two's-complement wrap). Binary point is unchanged.
module neuron_narrow_relu #(
  parameter int ACC_W = 30,
  parameter int N     = 24
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [N-1:0]     act
);

  localparam logic signed [ACC_W-1:0] MAX_EXT = (ACC_W'(1) <<< (N - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_EXT = -MAX_EXT - ACC_W'(1);

  function automatic logic signed [N-1:0] sat_narrow(input logic signed [ACC_W-1:0] v);
    if (v > MAX_EXT)      return MAX_EXT[N-1:0];
    else if (v < MIN_EXT) return MIN_EXT[N-1:0];
    else                  return v[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] relu(input logic signed [N-1:0] v);
    return v[N-1] ? '0 : v;
  endfunction

  logic signed [N-1:0] narrowed;

`ifdef NEURON_ACC_SAT_EN
  // Clamp to the representable N-bit range.
  always_comb narrowed = sat_narrow(sum);
`else
  // Wrap: discard the headroom bits.
  logic unused_hi;
  assign unused_hi = ^sum[ACC_W-1:N];
  always_comb narrowed = sum[N-1:0];
`endif

  // Negative activations are clipped to zero.
  always_comb act = relu(narrowed);

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates NUM_IN signed Q(N-P).P products, adds a bias, narrows and
// applies ReLU, then presents the activation on a valid/ready output.
// Optional build macro: NEURON_ACC_SAT_EN (saturating narrowing).
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int N      = 24,
  parameter int P      = 20,
  parameter int NUM_IN = 16
) (
  input logic               clk,
  input logic               rst_n,
  neuron_accumulator_if.slave io
);

  localparam int ACC_W = acc_width(N, NUM_IN);
  localparam int CNT_W = $clog2(NUM_IN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_IN - 1);

  if (NUM_IN < 1 || P < 0 || P > N) begin : g_param_check
    $error("neuron_accumulator: requires NUM_IN >= 1 and 0 <= P <= N");
  end

  state_e                  state_p0, state_nxt;
  logic signed [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [N-1:0]     act_p1;
  logic signed [ACC_W-1:0] in_ext, bias_ext, sum;
  logic signed [N-1:0]     act;
  logic                    fire, last;

  assign in_ext   = {{(ACC_W - N){io.in_data[N-1]}}, io.in_data};
  assign bias_ext = {{(ACC_W - N){io.bias[N-1]}}, io.bias};
  assign sum      = acc_p0 + in_ext + bias_ext;

  assign io.in_ready  = (state_p0 == ST_ACCUM);
  assign io.out_valid = (state_p0 == ST_OUT);
  assign io.out_data  = act_p1;
  assign io.beat_cnt  = cnt_p0;

  assign fire = io.in_valid && io.in_ready;
  assign last = fire && (cnt_p0 == LAST_CNT);

  neuron_narrow_relu #(
    .ACC_W (ACC_W),
    .N     (N)
  ) u_narrow_relu (
    .sum (sum),
    .act (act)
  );

  // Next state: leave ACCUM on the final beat, leave OUT when downstream takes it.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_ACCUM: if (last)         state_nxt = ST_OUT;
      ST_OUT:   if (io.out_ready) state_nxt = ST_ACCUM;
      default:                    state_nxt = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= ST_ACCUM;
    else        state_p0 <= state_nxt;
  end

  // --- stage p0: running sum and beat count; stage p1: registered activation ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      act_p1 <= '0;
    end else if (fire) begin
      if (last) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
        act_p1 <= act;
      end else begin
        acc_p0 <= acc_p0 + in_ext;
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator (N=24, P=20, NUM_IN=4).
// Expected results come from a queue-based reference model of the
// accumulate / bias / narrow / ReLU rules. Honours NEURON_ACC_SAT_EN.
module tb_neuron_accumulator;
  import neuron_pkg::*;

  localparam int N      = 24;
  localparam int P      = 20;
  localparam int NUM_IN = 4;

  logic clk;
  logic rst_n;

  neuron_accumulator_if #(.N(N), .NUM_IN(NUM_IN)) io ();

  neuron_accumulator #(.N(N), .P(P), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  longint beats[$];
  bit     pend;
  longint last_act;
  longint bias_v;
  int     results;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint ref_act(input longint b[$], input longint bs);
    longint s;
    longint lim_hi;
    longint lim_lo;
    s = bs;
    foreach (b[i]) s += b[i];
    lim_hi = (longint'(1) << (N - 1)) - 1;
    lim_lo = -(longint'(1) << (N - 1));
`ifdef NEURON_ACC_SAT_EN
    if (s > lim_hi) s = lim_hi;
    if (s < lim_lo) s = lim_lo;
`else
    s = s % (longint'(1) << N);
    if (s < 0) s += (longint'(1) << N);
    if (s > lim_hi) s -= (longint'(1) << N);
`endif
    return (s < 0) ? 0 : s;
  endfunction

  // One clock: drive inputs, check at the falling edge, advance the model
  // across the rising edge, return 1 time unit after that edge.
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic ordy);
    io.in_valid  = v;
    io.in_data   = d;
    io.out_ready = ordy;
    io.bias      = bias_v[N-1:0];
    @(negedge clk);
    chk("in_ready",  longint'(io.in_ready),  longint'(!pend));
    chk("out_valid", longint'(io.out_valid), longint'(pend));
    chk("beat_cnt",  longint'(io.beat_cnt),  longint'(beats.size()));
    chk("out_data",  longint'(io.out_data),  last_act);
    if (pend) begin
      if (ordy) pend = 1'b0;
    end else if (v) begin
      beats.push_back(longint'($signed(d)));
      if (beats.size() == NUM_IN) begin
        last_act = ref_act(beats, bias_v);
        pend     = 1'b1;
        results++;
        beats.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for one cycle starting just after a rising edge.
  task automatic do_reset();
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", longint'(io.out_valid), 0);
    chk("rst_out_data",  longint'(io.out_data),  0);
    chk("rst_in_ready",  longint'(io.in_ready),  1);
    chk("rst_beat_cnt",  longint'(io.beat_cnt),  0);
    beats.delete();
    pend     = 1'b0;
    last_act = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int bub_seq[7] = '{1, 1, 1, 2, 2, 3, 0};
  bit bub_v[7]   = '{1, 0, 0, 1, 0, 1, 1};
  logic [N-1:0] one;

  initial begin
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.bias      = '0;
    io.out_ready = 1'b0;
    pend         = 1'b0;
    last_act     = 0;
    bias_v       = 0;
    results      = 0;
    one          = N'(Q_ONE(P));
    @(posedge clk);
    #1;
    do_reset();

    // Basic sum: 4 x 1.0 + 0.5.
    bias_v = 64'h080000;
    for (int i = 0; i < NUM_IN; i++) begin
      cycle(1'b1, one, 1'b1);
      chk("basic_valid", longint'(io.out_valid), (i == NUM_IN - 1) ? 1 : 0);
    end
    chk("basic_sum", longint'(io.out_data), 64'h480000);
    cycle(1'b0, '0, 1'b1);

    // ReLU: 4 x -1.0.
    bias_v = 0;
    for (int i = 0; i < NUM_IN; i++) cycle(1'b1, 24'hF00000, 1'b1);
    chk("relu_valid", longint'(io.out_valid), 1);
    chk("relu_data",  longint'(io.out_data),  0);
    cycle(1'b0, '0, 1'b1);

    // Overflow: 4 x 3.0.
    for (int i = 0; i < NUM_IN; i++) cycle(1'b1, 24'h300000, 1'b1);
`ifdef NEURON_ACC_SAT_EN
    chk("ovf_data", longint'(io.out_data), 64'h7FFFFF);
`else
    chk("ovf_data", longint'(io.out_data), 0);
`endif

    // Backpressure: hold the result 5 cycles with in_valid high.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 24'h0F0000, 1'b0);
      chk("bp_in_ready", longint'(io.in_ready), 0);
    end
    cycle(1'b1, 24'h0F0000, 1'b1);
    for (int k = 1; k <= NUM_IN; k++) cycle(1'b1, N'(k * 64'h010000), 1'b1);
    chk("bp_next_sum", longint'(io.out_data), 64'h0A0000);
    cycle(1'b0, '0, 1'b1);

    // Bubbles.
    for (int i = 0; i < 7; i++) begin
      cycle(bub_v[i], one, 1'b0);
      chk("bub_cnt", longint'(io.beat_cnt), longint'(bub_seq[i]));
    end
    chk("bub_valid", longint'(io.out_valid), 1);
    chk("bub_data",  longint'(io.out_data),  64'h400000);
    cycle(1'b0, '0, 1'b1);
    chk("bub_single", longint'(io.out_valid), 0);

    // Mid-op reset: 2 x 2.0 then reset, then 4 x 1.0.
    cycle(1'b1, 24'h200000, 1'b1);
    cycle(1'b1, 24'h200000, 1'b1);
    do_reset();
    for (int i = 0; i < NUM_IN; i++) cycle(1'b1, one, 1'b1);
    chk("rst_resume", longint'(io.out_data), 64'h400000);
    cycle(1'b0, '0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if (beats.size() == 0 && $urandom_range(0, 3) == 0)
        bias_v = longint'($signed(N'($urandom)));
      cycle(($urandom_range(0, 3) != 0), N'($urandom), ($urandom_range(0, 2) != 0));
    end
    chk("rand_results_seen", longint'(results > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Sequential accumulate stage that sits directly downstream of the fixed-point multiplier in each neuron datapath. It consumes a stream of signed Q(N-P).P products and sums NUM_IN of them in a widened accumulator. It then adds a per-neuron bias, narrows the result back to N bits and applies ReLU. The activation is presented on a valid/ready output to the next layer.

## Interface
- `N`, default 24: product/activation width (matches multiplier `Nout`).
- `P`, default 20: fraction bits (matches multiplier `Pout`); format is Q(N-P).P.
- `NUM_IN`, default 16: products summed per neuron, ≥1.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: product beat valid.
- `in_ready`, out, 1: block accepts a product this cycle.
- `in_data`, in, N: signed product, Q(N-P).P.
- `bias`, in, N: signed bias, Q(N-P).P. Must be stable from the first beat of a neuron until `out_valid`.
- `out_valid`, out, 1: activation valid.
- `out_ready`, in, 1: downstream accepts the activation.
- `out_data`, out, N: signed activation, Q(N-P).P, always ≥0.
- `beat_cnt`, out, clog2(NUM_IN+1): number of products accepted for the current neuron (debug/verification).

## Operation
- Accumulator width is ACC_W = N + clog2(NUM_IN+1) + 1. Inputs and bias are sign-extended to ACC_W, so the accumulator never overflows internally.
- The block is a two-state FSM:
  - **ACCUM**
    - `in_ready`=1, `out_valid`=0.
    - Each beat with `in_valid`&&`in_ready`: acc += sext(`in_data`), `beat_cnt`++.
    - When the accepted beat is number NUM_IN:
      - sum = acc + sext(`in_data`) + sext(`bias`);
      - `out_data` <= relu(narrow(sum));
      - acc <= 0, `beat_cnt` <= 0;
      - go to OUT.
  - **OUT**
    - `in_ready`=0, `out_valid`=1, `out_data` held stable.
    - When `out_ready`=1: go to ACCUM, next cycle `out_valid`=0.
- Narrowing keeps the binary point; no rescaling.
  - With saturation enabled: clamp to [-2^(N-1), 2^(N-1)-1].
  - With saturation disabled: keep sum[N-1:0] (two's-complement wrap).
- ReLU: narrowed value with MSB=1 becomes 0; otherwise it passes unchanged.
- Cycles with `in_valid`=0 in ACCUM are bubbles. State, acc and count are unchanged.

## Timing
- Reset (async assert, sync-release assumed upstream) sets:
  - state = ACCUM, acc = 0, `beat_cnt` = 0;
  - `out_valid` = 0, `out_data` = 0;
  - `in_ready` = 1 (combinational from state).
- Latency: last product accepted at edge t gives `out_valid`=1 after edge t (visible in cycle t+1).
- Minimum neuron period is NUM_IN+1 cycles (NUM_IN input beats plus one OUT cycle with `out_ready`=1).
- Product and activation handoff cannot overlap: `in_ready`=0 for every cycle `out_valid`=1.
- `out_ready` asserted during ACCUM has no effect.
- `in_valid` held high during OUT does not consume data; upstream must hold the beat.
- Reset mid-accumulation discards the partial sum and count. The first beat after reset is beat 1 of a new neuron.
- Reset during OUT drops the pending activation.
- With NUM_IN=1, every accepted beat goes straight to OUT.

## Configuration
- Macro `NEURON_ACC_SAT_EN`.
  - Defined: saturating narrowing as above.
  - Undefined: wrap narrowing (truncate to low N bits, same slicing policy as the multiplier), no compare logic.
- The macro affects only the narrowing path. Handshake and timing are identical in both builds.

## Structure
- Shared package `neuron_pkg`:
  - state enum {ST_ACCUM, ST_OUT};
  - function `acc_width(N, NUM_IN)`;
  - Q-format constant `Q_ONE(P)` = 1<<P for benches.
- One sub-module, `neuron_narrow_relu`. It is combinational and parameterised by ACC_W and N. It holds the saturate/wrap choice (under `NEURON_ACC_SAT_EN`) and the ReLU.
- Top level holds the FSM, accumulator, counter and output register.

## Test plan
All scenarios use N=24, P=20, NUM_IN=4.
- **Basic sum:** 4 beats of 0x100000 (1.0), bias 0x080000 (0.5), `out_ready`=1 → `out_data`=0x480000 (4.5), `out_valid` one cycle after the 4th beat.
- **ReLU:** beats 0xF00000 ×4 (-1.0 each), bias 0 → `out_data`=0x000000, `out_valid`=1.
- **Overflow:** beats 0x300000 ×4 (3.0, sum 12.0), bias 0.
  - With `NEURON_ACC_SAT_EN`: `out_data`=0x7FFFFF.
  - Without it: wrapped 0xC00000 is negative → `out_data`=0x000000.
- **Backpressure:** after a result, hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, `out_data` stable, `beat_cnt`=0. Release → next neuron receives all 4 following beats with none lost or duplicated.
- **Bubbles:** beats 1.0 with `in_valid` toggling 1,0,0,1,0,1,1 → exactly one result 0x400000 (bias 0), `beat_cnt` sequence 1,1,1,2,2,3,0.
- **Mid-op reset:** accept 2 beats of 2.0, pulse `rst_n`=0 for 1 cycle, then send 4 beats of 0x100000 → `out_data`=0x400000, and `out_valid`/`out_data` read 0 during reset.
